// File: rtl/bcd_nines_comp_serial_decoder.sv
// rtl/bcd_nines_comp_serial_decoder.sv - deserializes 9's-complemented BCD digits and recovers 9 - code
module bcd_nines_comp_serial_decoder #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sync,
  output logic [3:0]       dout,
  output logic             dout_valid,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] digit_count
);

  logic [3:0] sr;
  logic [3:0] sr_next;
  logic [1:0] bit_cnt;
  logic [1:0] bit_cnt_next;
  logic       complete;
  logic       code_legal;

  // A sync bit always shifts in like a normal bit; stale fragment bits are
  // flushed out by the three bits that follow before the digit completes.
  always_comb begin
    sr_next      = sr;
    bit_cnt_next = bit_cnt;
    complete     = 1'b0;
    if (ser_valid) begin
      if (MSB_FIRST) sr_next = {sr[2:0], ser_in};
      else           sr_next = {ser_in, sr[3:1]};
      if (sync) begin
        bit_cnt_next = 2'd1;
      end else begin
        bit_cnt_next = bit_cnt + 2'd1;
        complete     = (bit_cnt == 2'd3);
      end
    end
  end

  assign code_legal = (sr_next <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= 4'd0;
      bit_cnt     <= 2'd0;
      busy        <= 1'b0;
      dout        <= 4'd0;
      dout_valid  <= 1'b0;
      err         <= 1'b0;
      digit_count <= '0;
    end else begin
      sr         <= sr_next;
      bit_cnt    <= bit_cnt_next;
      busy       <= (bit_cnt_next != 2'd0);
      dout_valid <= complete && code_legal;
      err        <= complete && !code_legal;
      if (complete && code_legal) begin
        dout        <= 4'd9 - sr_next;
        digit_count <= digit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_nines_comp_serial_decoder.sv
// tb/tb_bcd_nines_comp_serial_decoder.sv - scoreboard bench for the serial 9's-complement decoder
module tb_bcd_nines_comp_serial_decoder;

  typedef struct {
    logic       e;
    logic [3:0] d;
    int         c;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in = 1'b0, a_v = 1'b0, a_s = 1'b0;
  logic b_in = 1'b0, b_v = 1'b0, b_s = 1'b0;
  logic [3:0] a_dout, b_dout;
  logic       a_dv, a_err, a_busy, b_dv, b_err, b_busy;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  bcd_nines_comp_serial_decoder #(.MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ser_in(a_in), .ser_valid(a_v), .sync(a_s),
    .dout(a_dout), .dout_valid(a_dv), .err(a_err), .busy(a_busy), .digit_count(a_cnt)
  );

  bcd_nines_comp_serial_decoder #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ser_in(b_in), .ser_valid(b_v), .sync(b_s),
    .dout(b_dout), .dout_valid(b_dv), .err(b_err), .busy(b_busy), .digit_count(b_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int inst, input logic b, input logic v, input logic s,
                       input bit push, input logic e, input logic [3:0] d, input int c);
    exp_t x;
    @(negedge clk);
    if (inst == 0) begin a_in = b; a_v = v; a_s = s; end
    else           begin b_in = b; b_v = v; b_s = s; end
    if (push) begin
      x.e = e; x.d = d; x.c = c; x.t = cyc + 1;
      if (inst == 0) qa.push_back(x);
      else           qb.push_back(x);
    end
  endtask

  task automatic idle(input int inst);
    drive(inst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0);
  endtask

  task automatic send_digit(input int inst, input logic [3:0] code,
                            input logic e, input logic [3:0] d, input int c);
    for (int i = 0; i < 4; i++) begin
      logic bt;
      bt = (inst == 0) ? code[3-i] : code[i];
      drive(inst, bt, 1'b1, (i == 0), (i == 3), e, d, c);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_dv || a_err)) begin
      chk("a_exclusive", int'(a_dv & a_err), 0);
      if (qa.size() == 0) begin
        chk("a_spurious_pulse", 1, 0);
      end else begin
        exp_t x;
        x = qa.pop_front();
        chk("a_err", int'(a_err), int'(x.e));
        chk("a_dout", int'(a_dout), int'(x.d));
        chk("a_count", int'(a_cnt), x.c);
        chk("a_latency", cyc, x.t);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b_dv || b_err)) begin
      chk("b_exclusive", int'(b_dv & b_err), 0);
      if (qb.size() == 0) begin
        chk("b_spurious_pulse", 1, 0);
      end else begin
        exp_t x;
        x = qb.pop_front();
        chk("b_err", int'(b_err), int'(x.e));
        chk("b_dout", int'(b_dout), int'(x.d));
        chk("b_count", int'(b_cnt), x.c);
        chk("b_latency", cyc, x.t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", int'(a_dout), 0);
    chk("rst_dv", int'(a_dv), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_count", int'(a_cnt), 0);
    chk("rst_b_count", int'(b_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back legal digits
    send_digit(0, 4'b1001, 1'b0, 4'd0, 1);
    send_digit(0, 4'b0000, 1'b0, 4'd9, 2);
    send_digit(0, 4'b0101, 1'b0, 4'd4, 3);
    idle(0);
    idle(0);
    chk("busy_idle", int'(a_busy), 0);

    // Illegal codes: dout holds 4, count stays 3
    send_digit(0, 4'b1100, 1'b1, 4'd4, 3);
    send_digit(0, 4'b1111, 1'b1, 4'd4, 3);
    idle(0);

    // Code 0110 with valid gaps; sync during gaps must be ignored
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    chk("busy_gap1", int'(a_busy), 1);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    chk("busy_gap2", int'(a_busy), 1);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    chk("busy_gap3", int'(a_busy), 1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4);
    idle(0);
    chk("busy_after_gap_digit", int'(a_busy), 0);
    idle(0);

    // Two-bit fragment, then resync with 0111
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    send_digit(0, 4'b0111, 1'b0, 4'd2, 5);
    idle(0);
    idle(0);

    // Reset mid-digit
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    idle(0);
    chk("busy_before_rst", int'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_count", int'(a_cnt), 0);
    chk("midrst_dout", int'(a_dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_digit(0, 4'b0001, 1'b0, 4'd8, 1);
    idle(0);
    idle(0);

    // LSB-first instance, 2-bit counter wrap
    send_digit(1, 4'b0011, 1'b0, 4'd6, 1);
    send_digit(1, 4'b0011, 1'b0, 4'd6, 2);
    send_digit(1, 4'b0011, 1'b0, 4'd6, 3);
    send_digit(1, 4'b0011, 1'b0, 4'd6, 0);
    send_digit(1, 4'b0011, 1'b0, 4'd6, 1);
    idle(1);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
